// File: rtl/vector_dump_reader.sv
// Captures one frame of VECTOR_LEN scaled samples, then streams it out
// over a valid/ready port while later frames are dropped and counted.
module vector_dump_reader #(
  parameter int DIN_WIDTH  = 64,
  parameter int VECTOR_LEN = 64,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 16,
  parameter     DATA_TYPE  = "signed"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  overflow,
  output logic                  saturated,
  output logic [15:0]           frames_dropped
);

  localparam int AW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [AW-1:0] LAST = AW'(VECTOR_LEN - 1);
  localparam bit IS_SIGNED = (DATA_TYPE == "signed");

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  logic [1:0]            state;
  logic [AW-1:0]         idx;
  logic [AW-1:0]         cur_idx;
  logic [AW-1:0]         rd_ptr;
  logic                  sync_pend;
  logic [DOUT_WIDTH-1:0] mem [VECTOR_LEN];
  logic [DOUT_WIDTH-1:0] scaled;
  logic                  clip;
  logic                  is_first;
  logic                  is_last_in;
  logic                  wr_en;
  logic                  xfer;

  generate
    if (DOUT_WIDTH < DIN_WIDTH) begin : g_narrow
      if (IS_SIGNED) begin : g_s
        logic signed [DIN_WIDTH-1:0]    sh;
        logic [DIN_WIDTH-DOUT_WIDTH:0] top;
        assign sh  = $signed(din) >>> SHIFT;
        assign top = sh[DIN_WIDTH-1:DOUT_WIDTH-1];
        // in range only if all bits above the output sign bit match it
        assign clip = !((&top) || !(|top));
        assign scaled = !clip ? sh[DOUT_WIDTH-1:0] :
          top[DIN_WIDTH-DOUT_WIDTH] ?
            {1'b1, {(DOUT_WIDTH-1){1'b0}}} :
            {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end else begin : g_u
        logic [DIN_WIDTH-1:0] sh;
        assign sh     = din >> SHIFT;
        assign clip   = |sh[DIN_WIDTH-1:DOUT_WIDTH];
        assign scaled = clip ? '1 : sh[DOUT_WIDTH-1:0];
      end
    end else begin : g_wide
      if (IS_SIGNED) begin : g_s
        logic signed [DIN_WIDTH-1:0] sh;
        assign sh     = $signed(din) >>> SHIFT;
        assign scaled = DOUT_WIDTH'(sh);
      end else begin : g_u
        logic [DIN_WIDTH-1:0] sh;
        assign sh     = din >> SHIFT;
        assign scaled = DOUT_WIDTH'(sh);
      end
      assign clip = 1'b0;
    end
  endgenerate

  assign cur_idx    = (sync || sync_pend) ? '0 : idx;
  assign is_first   = din_valid && (cur_idx == '0);
  assign is_last_in = din_valid && (cur_idx == LAST);
  assign xfer       = dout_valid && dout_ready;
  assign wr_en      = din_valid &&
    ((state == CAPTURE) || ((state == IDLE) && (cur_idx == '0)));

  always_ff @(posedge clk) begin
    if (wr_en) mem[cur_idx] <= scaled;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      sync_pend      <= 1'b0;
      rd_ptr         <= '0;
      dout           <= '0;
      dout_valid     <= 1'b0;
      dout_last      <= 1'b0;
      overflow       <= 1'b0;
      saturated      <= 1'b0;
      frames_dropped <= '0;
    end else begin
      if (din_valid) begin
        idx       <= cur_idx + 1'b1;
        sync_pend <= 1'b0;
      end else if (sync) begin
        sync_pend <= 1'b1;
      end
      if (wr_en && clip) saturated <= 1'b1;
      unique case (state)
        IDLE: begin
          if (is_first) state <= CAPTURE;
        end
        CAPTURE: begin
          // sync with a sample restarts at slot 0; without one, abort
          if (sync && !din_valid) begin
            state <= IDLE;
          end else if (is_last_in) begin
            state      <= DRAIN;
            dout       <= mem[0];
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
            rd_ptr     <= AW'(1);
          end
        end
        DRAIN: begin
          if (is_first) begin
            overflow <= 1'b1;
            if (frames_dropped != 16'hFFFF)
              frames_dropped <= frames_dropped + 16'd1;
          end
          if (xfer) begin
            if (dout_last) begin
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              state      <= IDLE;
            end else begin
              dout      <= mem[rd_ptr];
              dout_last <= (rd_ptr == LAST);
              rd_ptr    <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dump_reader.sv
// Directed bench: frame capture, stalls, drops, sync abort,
// mid-drain reset and signed saturation.
module tb_vector_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_a;
  logic [31:0] din_a;
  logic        din_valid_a;
  logic [31:0] dout_a;
  logic        dout_valid_a;
  logic        dout_ready_a;
  logic        dout_last_a;
  logic        overflow_a;
  logic        saturated_a;
  logic [15:0] frames_dropped_a;

  logic        sync_b;
  logic [63:0] din_b;
  logic        din_valid_b;
  logic [15:0] dout_b;
  logic        dout_valid_b;
  logic        dout_ready_b;
  logic        dout_last_b;
  logic        overflow_b;
  logic        saturated_b;
  logic [15:0] frames_dropped_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_a[$];
  logic [15:0] got_b[$];
  int          last_at;
  int          last_cnt;
  int          stab_err;
  logic        prev_stall;
  logic [31:0] prev_dout;
  logic        prev_last;

  always #5 clk = ~clk;

  vector_dump_reader #(
    .DIN_WIDTH(32), .VECTOR_LEN(8), .DOUT_WIDTH(32),
    .SHIFT(0), .DATA_TYPE("signed")
  ) dut_a (
    .clk(clk), .rst(rst), .sync(sync_a), .din(din_a),
    .din_valid(din_valid_a), .dout(dout_a),
    .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .dout_last(dout_last_a), .overflow(overflow_a),
    .saturated(saturated_a), .frames_dropped(frames_dropped_a)
  );

  vector_dump_reader #(
    .DIN_WIDTH(64), .VECTOR_LEN(8), .DOUT_WIDTH(16),
    .SHIFT(16), .DATA_TYPE("signed")
  ) dut_b (
    .clk(clk), .rst(rst), .sync(sync_b), .din(din_b),
    .din_valid(din_valid_b), .dout(dout_b),
    .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .dout_last(dout_last_b), .overflow(overflow_b),
    .saturated(saturated_b), .frames_dropped(frames_dropped_b)
  );

  always @(posedge clk) begin
    if (prev_stall && dout_valid_a &&
        (dout_a !== prev_dout || dout_last_a !== prev_last))
      stab_err <= stab_err + 1;
    prev_stall <= dout_valid_a && !dout_ready_a;
    prev_dout  <= dout_a;
    prev_last  <= dout_last_a;
    if (dout_valid_a && dout_ready_a) begin
      if (dout_last_a) begin
        last_at  <= got_a.size();
        last_cnt <= last_cnt + 1;
      end
      got_a.push_back(dout_a);
    end
    if (dout_valid_b && dout_ready_b) got_b.push_back(dout_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_a.delete();
    last_at  = -1;
    last_cnt = 0;
    stab_err = 0;
  endtask

  task automatic send_a(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      din_a       = base + 32'(k);
      din_valid_a = 1'b1;
      step();
    end
    din_valid_a = 1'b0;
  endtask

  task automatic wait_a(input int n, input bit toggle);
    logic [3:0] pat;
    pat = 4'b1001;
    for (int c = 0; c < 100 && got_a.size() < n; c++) begin
      dout_ready_a = toggle ? pat[c % 4] : 1'b1;
      step();
    end
    dout_ready_a = 1'b1;
    chk("word_count", 64'(got_a.size()), 64'(n));
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] base);
    for (int k = 0; k < 8; k++)
      chk(tag, 64'(got_a[k]), 64'(base + 32'(k)));
    chk({tag, "_last_at"}, 64'(last_at), 64'd7);
    chk({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    sync_a = 1'b0; din_a = '0; din_valid_a = 1'b0; dout_ready_a = 1'b1;
    sync_b = 1'b0; din_b = '0; din_valid_b = 1'b0; dout_ready_b = 1'b1;
    prev_stall = 1'b0; prev_dout = '0; prev_last = 1'b0;
    clear_mon();
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(dout_valid_a), 64'd0);
    chk("rst_dout", 64'(dout_a), 64'd0);
    chk("rst_last", 64'(dout_last_a), 64'd0);
    chk("rst_ovf", 64'(overflow_a), 64'd0);
    chk("rst_sat", 64'(saturated_a), 64'd0);
    chk("rst_fd", 64'(frames_dropped_a), 64'd0);

    // basic frame, ready held high
    dout_ready_a = 1'b1;
    send_a(32'd0, 8);
    lat = 0;
    while (!dout_valid_a && lat < 10) begin
      step();
      lat++;
    end
    chk("latency_ok", 64'(lat <= 4), 64'd1);
    wait_a(8, 1'b0);
    chk_frame("basic", 32'd0);
    chk("basic_ovf", 64'(overflow_a), 64'd0);
    chk("basic_sat", 64'(saturated_a), 64'd0);

    // ready toggling 1,0,0,1 during drain
    clear_mon();
    dout_ready_a = 1'b0;
    send_a(32'h50, 8);
    wait_a(8, 1'b1);
    step(); step();
    chk_frame("stall", 32'h50);
    chk("stall_stable", 64'(stab_err), 64'd0);

    // sync abort after index 2, then a fresh frame
    clear_mon();
    send_a(32'd300, 3);
    sync_a = 1'b1;
    step();
    sync_a = 1'b0;
    send_a(32'd400, 8);
    wait_a(8, 1'b0);
    step(); step(); step();
    chk("sync_words", 64'(got_a.size()), 64'd8);
    chk_frame("sync", 32'd400);
    chk("sync_ovf", 64'(overflow_a), 64'd0);

    // second frame while stalled is dropped
    clear_mon();
    dout_ready_a = 1'b0;
    send_a(32'd100, 8);
    step();
    send_a(32'd200, 8);
    step();
    chk("drop_ovf", 64'(overflow_a), 64'd1);
    chk("drop_fd", 64'(frames_dropped_a), 64'd1);
    chk("drop_held", 64'(dout_a), 64'd100);
    wait_a(8, 1'b0);
    step(); step(); step();
    chk("drop_words", 64'(got_a.size()), 64'd8);
    chk_frame("drop", 32'd100);

    // reset at drain word 4
    clear_mon();
    dout_ready_a = 1'b0;
    send_a(32'd500, 8);
    dout_ready_a = 1'b1;
    step(); step(); step(); step();
    dout_ready_a = 1'b0;
    chk("pre_rst_words", 64'(got_a.size()), 64'd4);
    chk("pre_rst_dout", 64'(dout_a), 64'd504);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(dout_valid_a), 64'd0);
    chk("mid_rst_dout", 64'(dout_a), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_a), 64'd0);
    chk("mid_rst_fd", 64'(frames_dropped_a), 64'd0);
    chk("mid_rst_sat", 64'(saturated_a), 64'd0);
    clear_mon();
    dout_ready_a = 1'b1;
    send_a(32'd600, 8);
    wait_a(8, 1'b0);
    chk_frame("after_rst", 32'd600);

    // signed saturation on the narrow instance
    chk("sat_pre", 64'(saturated_b), 64'd0);
    for (int k = 0; k < 8; k++) begin
      unique case (k)
        0: din_b = 64'h0000_7FFF_0000_0000;
        1: din_b = 64'hFFFF_FFFF_0000_0000;
        2: din_b = 64'h0000_0000_1234_0000;
        3: din_b = 64'hFFFF_FFFF_EDCC_0000;
        default: din_b = 64'(k) << 16;
      endcase
      din_valid_b = 1'b1;
      step();
    end
    din_valid_b = 1'b0;
    for (int c = 0; c < 40 && got_b.size() < 8; c++) step();
    chk("sat_words", 64'(got_b.size()), 64'd8);
    chk("sat_pos", 64'(got_b[0]), 64'h7FFF);
    chk("sat_neg", 64'(got_b[1]), 64'h8000);
    chk("sat_pass", 64'(got_b[2]), 64'h1234);
    chk("sat_negok", 64'(got_b[3]), 64'hEDCC);
    chk("sat_w7", 64'(got_b[7]), 64'h0007);
    chk("sat_flag", 64'(saturated_b), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
